// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - data memory port owner: INIT fill sequencer plus two-requester round-robin arbiter
//
// Purpose:
//   Owns the single data memory port. After reset an INIT sequencer writes
//   word i with value i for every word, then two requesters (r0 = datapath
//   load/store, r1 = debug/loader) share the port with round-robin arbitration.
//   Each grant is a one-cycle access; read data returns the following cycle.
//
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   o_init_done                 high once the INIT fill has completed
//   i_rX_req/we/addr/wdata      requester X access (held until o_rX_gnt)
//   o_rX_gnt                    combinational grant, access happens this cycle
//   o_rX_rvalid/o_rX_rdata      registered read return, cycle after a read grant
//   o_rX_err                    registered pulse, cycle after an out-of-range grant
//   o_mem_*                     memory command outputs
//   i_mem_read_data             memory read data, valid in the o_mem_read cycle

module data_mem_arbiter #(
    parameter int DEPTH   = 32,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_init_done,

    input  logic              i_r0_req,
    input  logic              i_r0_we,
    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [DATA_W-1:0] i_r0_wdata,
    output logic              o_r0_gnt,
    output logic              o_r0_rvalid,
    output logic [DATA_W-1:0] o_r0_rdata,
    output logic              o_r0_err,

    input  logic              i_r1_req,
    input  logic              i_r1_we,
    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic [DATA_W-1:0] i_r1_wdata,
    output logic              o_r1_gnt,
    output logic              o_r1_rvalid,
    output logic [DATA_W-1:0] o_r1_rdata,
    output logic              o_r1_err,

    output logic              o_mem_write,
    output logic              o_mem_read,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_write_data,
    input  logic [DATA_W-1:0] i_mem_read_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rr;        // 0: r0 wins a tie, 1: r1 wins a tie
    logic               r_init_done;
    logic               r_r0_rvalid;
    logic [DATA_W-1:0]  r_r0_rdata;
    logic               r_r0_err;
    logic               r_r1_rvalid;
    logic [DATA_W-1:0]  r_r1_rdata;
    logic               r_r1_err;

    logic               w_in_init;
    logic               w_in_arb;
    logic               w_r0_gnt;
    logic               w_r1_gnt;
    logic               w_gnt;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_oor;

    // Port is quiet while reset is asserted so nothing reaches memory then.
    always_comb begin
        w_in_init   = (r_state == ST_INIT) && !i_reset;
        w_in_arb    = (r_state == ST_ARB) && !i_reset;
        w_r0_gnt    = w_in_arb && i_r0_req && (!i_r1_req || !r_rr);
        w_r1_gnt    = w_in_arb && i_r1_req && (!i_r0_req || r_rr);
        w_gnt       = w_r0_gnt || w_r1_gnt;
        w_sel_we    = w_r1_gnt ? i_r1_we    : i_r0_we;
        w_sel_addr  = w_r1_gnt ? i_r1_addr  : i_r0_addr;
        w_sel_wdata = w_r1_gnt ? i_r1_wdata : i_r0_wdata;
        // Full-width compare: high address bits must not alias into range.
        w_oor       = w_sel_addr >= ADDR_W'(DEPTH);
    end

    always_comb begin
        o_mem_write      = 1'b0;
        o_mem_read       = 1'b0;
        o_mem_address    = '0;
        o_mem_write_data = '0;
        if (w_in_init) begin
            o_mem_write      = 1'b1;
            o_mem_address    = ADDR_W'(r_cnt);
            o_mem_write_data = DATA_W'(r_cnt);
        end else if (w_gnt) begin
            o_mem_address = w_sel_addr;
            if (!w_oor) begin
                o_mem_write = w_sel_we;
                o_mem_read  = !w_sel_we;
            end
            if (w_sel_we) begin
                o_mem_write_data = w_sel_wdata;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= INIT_EN ? ST_INIT : ST_ARB;
            r_cnt       <= '0;
            r_rr        <= 1'b0;
            r_init_done <= !INIT_EN;
            r_r0_rvalid <= 1'b0;
            r_r0_rdata  <= '0;
            r_r0_err    <= 1'b0;
            r_r1_rvalid <= 1'b0;
            r_r1_rdata  <= '0;
            r_r1_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DEPTH - 1)) begin
                        r_state     <= ST_ARB;
                        r_init_done <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (w_gnt) begin
                        r_rr <= w_r0_gnt;
                    end
                end
                default: r_state <= ST_ARB;
            endcase

            // An out-of-range read still returns a valid beat, with zero data.
            r_r0_rvalid <= w_r0_gnt && !w_sel_we;
            r_r0_rdata  <= (w_r0_gnt && !w_sel_we && !w_oor) ? i_mem_read_data : '0;
            r_r0_err    <= w_r0_gnt && w_oor;
            r_r1_rvalid <= w_r1_gnt && !w_sel_we;
            r_r1_rdata  <= (w_r1_gnt && !w_sel_we && !w_oor) ? i_mem_read_data : '0;
            r_r1_err    <= w_r1_gnt && w_oor;
        end
    end

    assign o_init_done = r_init_done;
    assign o_r0_gnt    = w_r0_gnt;
    assign o_r1_gnt    = w_r1_gnt;
    assign o_r0_rvalid = r_r0_rvalid;
    assign o_r0_rdata  = r_r0_rdata;
    assign o_r0_err    = r_r0_err;
    assign o_r1_rvalid = r_r1_rvalid;
    assign o_r1_rdata  = r_r1_rdata;
    assign o_r1_err    = r_r1_err;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter

module tb_data_mem_arbiter;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_done;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32), .INIT_EN(1'b1)) dut (
        .i_clk(clk), .i_reset(reset), .o_init_done(init_done),
        .i_r0_req(r0_req), .i_r0_we(r0_we), .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata),
        .o_r0_gnt(r0_gnt), .o_r0_rvalid(r0_rvalid), .o_r0_rdata(r0_rdata), .o_r0_err(r0_err),
        .i_r1_req(r1_req), .i_r1_we(r1_we), .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata),
        .o_r1_gnt(r1_gnt), .o_r1_rvalid(r1_rvalid), .o_r1_rdata(r1_rdata), .o_r1_err(r1_err),
        .o_mem_write(mem_write), .o_mem_read(mem_read), .o_mem_address(mem_address),
        .o_mem_write_data(mem_write_data), .i_mem_read_data(mem_read_data)
    );

    // Memory attached to the port; out-of-range reads return junk.
    logic [31:0] sim_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_write && mem_address < DEPTH) sim_mem[mem_address[4:0]] <= mem_write_data;
    end
    assign mem_read_data = (mem_address < DEPTH) ? sim_mem[mem_address[4:0]] : 32'hBAD0_BAD0;

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    bit          m_init = 1'b1;
    bit          m_init_done = 1'b0;
    int          m_cnt = 0;
    int          m_rr = 0;
    int          last_g = -1;
    bit          e_rv [2] = '{1'b0, 1'b0};
    bit          e_err [2] = '{1'b0, 1'b0};
    logic [31:0] e_rd [2] = '{32'h0, 32'h0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after the falling edge with inputs already applied; checks
    // this cycle's outputs, advances the model and returns at the next falling edge.
    task automatic run_cycle();
        bit          rq [2];
        bit          w [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        int          g;
        bit          oor;
        rq[0] = r0_req; w[0] = r0_we; a[0] = r0_addr; d[0] = r0_wdata;
        rq[1] = r1_req; w[1] = r1_we; a[1] = r1_addr; d[1] = r1_wdata;
        last_g = -1;
        #1;
        chk("init_done", {31'b0, init_done}, {31'b0, m_init_done});
        chk("r0_rvalid", {31'b0, r0_rvalid}, {31'b0, e_rv[0]});
        chk("r1_rvalid", {31'b0, r1_rvalid}, {31'b0, e_rv[1]});
        chk("r0_err", {31'b0, r0_err}, {31'b0, e_err[0]});
        chk("r1_err", {31'b0, r1_err}, {31'b0, e_err[1]});
        if (e_rv[0]) chk("r0_rdata", r0_rdata, e_rd[0]);
        if (e_rv[1]) chk("r1_rdata", r1_rdata, e_rd[1]);
        e_rv = '{1'b0, 1'b0};
        e_err = '{1'b0, 1'b0};
        if (reset) begin
            chk("rst_gnt0", {31'b0, r0_gnt}, 32'd0);
            chk("rst_gnt1", {31'b0, r1_gnt}, 32'd0);
            chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
            chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
            m_init = 1'b1; m_init_done = 1'b0; m_cnt = 0; m_rr = 0;
        end else if (m_init) begin
            chk("init_mem_write", {31'b0, mem_write}, 32'd1);
            chk("init_mem_read", {31'b0, mem_read}, 32'd0);
            chk("init_addr", mem_address, m_cnt);
            chk("init_data", mem_write_data, m_cnt);
            chk("init_gnt0", {31'b0, r0_gnt}, 32'd0);
            chk("init_gnt1", {31'b0, r1_gnt}, 32'd0);
            ref_mem[m_cnt] = m_cnt;
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_init = 1'b0;
                m_init_done = 1'b1;
            end
        end else begin
            if (rq[0] && rq[1]) g = m_rr;
            else if (rq[0]) g = 0;
            else if (rq[1]) g = 1;
            else g = -1;
            chk("gnt0", {31'b0, r0_gnt}, (g == 0) ? 32'd1 : 32'd0);
            chk("gnt1", {31'b0, r1_gnt}, (g == 1) ? 32'd1 : 32'd0);
            if (g < 0) begin
                chk("idle_mem_write", {31'b0, mem_write}, 32'd0);
                chk("idle_mem_read", {31'b0, mem_read}, 32'd0);
                chk("idle_addr", mem_address, 32'd0);
                chk("idle_wdata", mem_write_data, 32'd0);
            end else begin
                oor = (a[g] >= DEPTH);
                chk("gnt_addr", mem_address, a[g]);
                chk("gnt_mem_write", {31'b0, mem_write}, {31'b0, !oor && w[g]});
                chk("gnt_mem_read", {31'b0, mem_read}, {31'b0, !oor && !w[g]});
                if (!oor && w[g]) chk("gnt_wdata", mem_write_data, d[g]);
                e_err[g] = oor;
                e_rv[g]  = !w[g];
                e_rd[g]  = (oor || w[g]) ? 32'h0 : ref_mem[a[g][4:0]];
                if (!oor && w[g]) ref_mem[a[g][4:0]] = d[g];
                m_rr = 1 - g;
                last_g = g;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'(DEPTH + $urandom_range(0, 15));
        if (sel == 1) return 32'h100 | 32'($urandom_range(0, DEPTH - 1));
        return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        reset = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        repeat (2) @(negedge clk);
        run_cycle();

        // T1/T2: INIT fill with r0 read of addr 5 held throughout
        reset = 1'b0;
        r0_req = 1; r0_we = 0; r0_addr = 5;
        while (m_init) run_cycle();
        run_cycle();
        r0_req = 0;
        run_cycle();

        // T3: write then read back the same address
        r0_req = 1; r0_we = 1; r0_addr = 7; r0_wdata = 32'h0000_DEAD;
        run_cycle();
        r0_we = 0;
        run_cycle();
        r0_req = 0;
        run_cycle();

        // Single r1 grant so the tie pointer favours r0 again
        r1_req = 1; r1_we = 0; r1_addr = 3;
        run_cycle();
        r1_req = 0;
        run_cycle();

        // T4: both held for 4 cycles -> r0,r1,r0,r1
        r0_req = 1; r0_we = 0; r0_addr = 1;
        r1_req = 1; r1_we = 0; r1_addr = 2;
        repeat (4) run_cycle();
        r0_req = 0; r1_req = 0;
        run_cycle();

        // T5: out-of-range read, aliasing write, then confirm word 5 untouched
        r1_req = 1; r1_we = 0; r1_addr = 40;
        run_cycle();
        r1_we = 1; r1_addr = 32'h105; r1_wdata = 32'h1234_5678;
        run_cycle();
        r1_req = 0;
        r0_req = 1; r0_we = 0; r0_addr = 5;
        run_cycle();
        r0_req = 0;
        run_cycle();

        // Randomized traffic; requests held until granted
        for (int i = 0; i < 400; i++) begin
            if (!r0_req && $urandom_range(0, 1) == 1) begin
                r0_req = 1; r0_we = 1'($urandom_range(0, 1));
                r0_addr = rand_addr(); r0_wdata = $urandom;
            end
            if (!r1_req && $urandom_range(0, 1) == 1) begin
                r1_req = 1; r1_we = 1'($urandom_range(0, 1));
                r1_addr = rand_addr(); r1_wdata = $urandom;
            end
            run_cycle();
            if (last_g == 0) r0_req = 0;
            if (last_g == 1) r1_req = 0;
        end
        r0_req = 0; r1_req = 0;
        run_cycle();

        // Reset in ARB with a read pending and one just granted
        r0_req = 1; r0_we = 0; r0_addr = 9;
        run_cycle();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0; r0_req = 0;

        // T6: reset again at INIT cnt=10, fill restarts from 0
        while (m_cnt < 10) run_cycle();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        while (m_init) run_cycle();

        r1_req = 1; r1_we = 0; r1_addr = 10;
        run_cycle();
        r1_req = 0;
        run_cycle();
        run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
